// File: rtl/if_fetch_queue_pkg.sv
// rtl/if_fetch_queue_pkg.sv - shared constants and fetch-action type for the instruction-fetch stage
`timescale 1ns/1ps
package if_fetch_queue_pkg;
  localparam int          XLEN_DEF     = 32;
  localparam int          IMEM_SIZE    = 64;
  localparam logic [31:0] RESET_PC_DEF = 32'h0;
  localparam logic [31:0] NOP_INS      = 32'h0000_0000;

  typedef enum logic [1:0] {
    ACT_IDLE  = 2'd0,
    ACT_PUSH  = 2'd1,
    ACT_FLUSH = 2'd2
  } fetch_act_e;
endpackage

// File: rtl/pc_ins_fifo.sv
// rtl/pc_ins_fifo.sv - synchronous FIFO of {PC, instruction} pairs with flush
`timescale 1ns/1ps
module pc_ins_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
endmodule

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - fetch PC, local instruction memory and decoupling queue ahead of decode
`timescale 1ns/1ps
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int              XLEN       = XLEN_DEF,
  parameter int              IMEM_DEPTH = IMEM_SIZE,
  parameter int              QDEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEF)
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            WE,
  input  logic [XLEN-1:0] W_Addr,
  input  logic [XLEN-1:0] W_Ins,
  input  logic            Redirect,
  input  logic [XLEN-1:0] NewPC,
  output logic            Out_Valid,
  input  logic            Out_Ready,
  output logic [XLEN-1:0] Out_PC,
  output logic [XLEN-1:0] Out_NextPC,
  output logic [XLEN-1:0] Out_Ins
);
  localparam int IW = $clog2(IMEM_DEPTH);
  localparam int CW = $clog2(QDEPTH) + 1;

  logic [XLEN-1:0]   imem [IMEM_DEPTH];
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   last_pc_q, last_pc_d, last_ins_q, last_ins_d;
  logic [XLEN-1:0]   fetch_ins, head_pc, head_ins;
  logic [2*XLEN-1:0] fifo_rdata;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_flush, pop;
  logic              unused_ok;
  fetch_act_e        act;

  always_ff @(posedge CLK) begin
    if (WE) imem[W_Addr[IW+1:2]] <= W_Ins;
  end

  assign fetch_ins = imem[fetch_pc_q[IW+1:2]];
  assign pop       = Out_Valid && Out_Ready;

  // Redirect outranks everything; a write steals the fetch slot for one cycle.
  always_comb begin
    act = ACT_IDLE;
    if (Redirect)                              act = ACT_FLUSH;
    else if (!WE && (!fifo_full || pop))       act = ACT_PUSH;
  end

  assign fifo_push  = (act == ACT_PUSH);
  assign fifo_flush = (act == ACT_FLUSH);
  assign fifo_pop   = pop && (act != ACT_FLUSH);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    case (act)
      ACT_FLUSH: fetch_pc_d = {NewPC[XLEN-1:2], 2'b00};
      ACT_PUSH:  fetch_pc_d = fetch_pc_q + XLEN'(4);
      default:   fetch_pc_d = fetch_pc_q;
    endcase
  end

  pc_ins_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .wdata ({fetch_pc_q, fetch_ins}),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_pc  = fifo_rdata[2*XLEN-1:XLEN];
  assign head_ins = fifo_rdata[XLEN-1:0];

  // While empty, the outputs replay the last head shown rather than stale storage.
  assign Out_Valid  = !fifo_empty;
  assign Out_PC     = fifo_empty ? last_pc_q  : head_pc;
  assign Out_Ins    = fifo_empty ? last_ins_q : head_ins;
  assign Out_NextPC = Out_PC + XLEN'(4);

  always_comb begin
    last_pc_d  = Out_PC;
    last_ins_d = Out_Ins;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fetch_pc_q <= RESET_PC;
      last_pc_q  <= '0;
      last_ins_q <= XLEN'(NOP_INS);
    end else begin
      fetch_pc_q <= fetch_pc_d;
      last_pc_q  <= last_pc_d;
      last_ins_q <= last_ins_d;
    end
  end

  assign unused_ok = ^{fifo_count, W_Addr[XLEN-1:IW+2], W_Addr[1:0], NewPC[1:0]};
endmodule
